// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song screen drawer: FSM state encoding, lane
// colour constants, default field geometry and small elaboration helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package song_pkg;

   // Drawer FSM states
   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_SHIFT,
      ST_DRAW,
      ST_DONE
   } drawState_t;

   // Lane colours; lanes beyond 4 reuse these modulo 4
   localparam logic [2:0] LANE0        = 3'b100;
   localparam logic [2:0] LANE1        = 3'b010;
   localparam logic [2:0] LANE2        = 3'b001;
   localparam logic [2:0] LANE3        = 3'b110;
   localparam logic [2:0] COLOUR_EMPTY = 3'b000;
   localparam logic [2:0] COLOUR_LINE  = 3'b111;

   // Default field geometry (fits inside the 160x120 VGA frame)
   localparam int unsigned DEFAULT_ROWS   = 8;
   localparam int unsigned DEFAULT_LANES  = 4;
   localparam int unsigned DEFAULT_CELL_W = 4;
   localparam int unsigned DEFAULT_CELL_H = 4;
   localparam int unsigned DEFAULT_X0     = 48;
   localparam int unsigned DEFAULT_Y0     = 8;

   // Counter width for a modulo-n count; never narrower than one bit
   function automatic int unsigned cntWidth(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Colour assigned to a lane index
   function automatic logic [2:0] laneColour(input int unsigned lane);
      case (lane % 4)
         0:       return LANE0;
         1:       return LANE1;
         2:       return LANE2;
         default: return LANE3;
      endcase
   endfunction

endpackage

// File: rtl/song_screen_drawer_pixel_scan_counter.sv
// ---------------------------------------------------------------------------
// pixel_scan_counter
// Nested scan counters for the note field: px counts fastest, then py, then
// lane, then row. Wraps to all-zero after the final pixel.
// Ports:
//   clock   - system clock
//   clear   - synchronous clear to pixel 0 (dominates enable)
//   enable  - advance one pixel
//   px, py  - pixel offset inside the current cell
//   lane    - current lane (column of cells)
//   row     - current row (row 0 = top)
//   last    - registered flag: counter currently points at the final pixel
// ---------------------------------------------------------------------------
module pixel_scan_counter
   import song_pkg::*;
#(
   parameter int unsigned ROWS   = DEFAULT_ROWS,
   parameter int unsigned LANES  = DEFAULT_LANES,
   parameter int unsigned CELL_W = DEFAULT_CELL_W,
   parameter int unsigned CELL_H = DEFAULT_CELL_H
) (
   input  logic                                clock,
   input  logic                                clear,
   input  logic                                enable,
   output logic [cntWidth(CELL_W)-1:0]         px,
   output logic [cntWidth(CELL_H)-1:0]         py,
   output logic [cntWidth(LANES)-1:0]          lane,
   output logic [cntWidth(ROWS)-1:0]           row,
   output logic                                last
);

   localparam int unsigned PX_W   = cntWidth(CELL_W);
   localparam int unsigned PY_W   = cntWidth(CELL_H);
   localparam int unsigned LANE_W = cntWidth(LANES);
   localparam int unsigned ROW_W  = cntWidth(ROWS);
   localparam bit          SINGLE = ((ROWS * LANES * CELL_W * CELL_H) == 1);

   logic              pxWrap;
   logic              pyWrap;
   logic              laneWrap;
   logic              rowWrap;
   logic [PX_W-1:0]   pxNext;
   logic [PY_W-1:0]   pyNext;
   logic [LANE_W-1:0] laneNext;
   logic [ROW_W-1:0]  rowNext;
   logic              lastNext;

   // Ripple-style carry between the four nested counters
   always_comb begin
      pxWrap   = (px   == PX_W'(CELL_W - 1));
      pyWrap   = (py   == PY_W'(CELL_H - 1));
      laneWrap = (lane == LANE_W'(LANES - 1));
      rowWrap  = (row  == ROW_W'(ROWS - 1));

      pxNext   = pxWrap ? '0 : px + PX_W'(1);
      pyNext   = py;
      laneNext = lane;
      rowNext  = row;
      if (pxWrap) begin
         pyNext = pyWrap ? '0 : py + PY_W'(1);
      end
      if (pxWrap && pyWrap) begin
         laneNext = laneWrap ? '0 : lane + LANE_W'(1);
      end
      if (pxWrap && pyWrap && laneWrap) begin
         rowNext = rowWrap ? '0 : row + ROW_W'(1);
      end

      lastNext = (pxNext   == PX_W'(CELL_W - 1)) &&
                 (pyNext   == PY_W'(CELL_H - 1)) &&
                 (laneNext == LANE_W'(LANES - 1)) &&
                 (rowNext  == ROW_W'(ROWS - 1));
   end

   // Counter registers; last is precomputed so it lines up with the position
   always_ff @(posedge clock) begin
      if (clear) begin
         px   <= '0;
         py   <= '0;
         lane <= '0;
         row  <= '0;
         last <= SINGLE;
      end else if (enable) begin
         px   <= pxNext;
         py   <= pyNext;
         lane <= laneNext;
         row  <= rowNext;
         last <= lastNext;
      end
   end

endmodule

// File: rtl/song_screen_drawer.sv
// ---------------------------------------------------------------------------
// song_screen_drawer
// Scrolling note field for the song sequencer. On shiftSong (in IDLE) the
// field scrolls down one row taking noteIn into the top row, then the whole
// field is redrawn one pixel per cycle into the VGA adapter. readyForSong
// pulses when the redraw finishes; the bottom row's note exits on hitRow.
// After reset a blank field is drawn and readyForSong pulses once.
//
// Optional feature macro: SONG_SCREEN_HIT_LINE_EN
//   When defined, a white hit line (LANES*CELL_W pixels) is drawn just below
//   the field after each redraw, delaying readyForSong by that many cycles.
//
// Ports:
//   clock        - system clock (posedge)
//   resetn       - synchronous active-low reset
//   shiftSong    - one-cycle scroll+redraw request (ignored unless IDLE)
//   noteIn       - current song note, sampled in the SHIFT cycle
//   readyForSong - one-cycle pulse after the redraw completes
//   hitRow       - note word that scrolled out of the bottom row
//   x, y         - VGA pixel coordinate (0 when plot=0)
//   colour       - VGA pixel colour (0 when plot=0)
//   plot         - VGA write enable
//   busy         - high in every state except IDLE
// ---------------------------------------------------------------------------
module song_screen_drawer
   import song_pkg::*;
#(
   parameter int unsigned ROWS   = DEFAULT_ROWS,
   parameter int unsigned LANES  = DEFAULT_LANES,
   parameter int unsigned CELL_W = DEFAULT_CELL_W,
   parameter int unsigned CELL_H = DEFAULT_CELL_H,
   parameter int unsigned X0     = DEFAULT_X0,
   parameter int unsigned Y0     = DEFAULT_Y0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             shiftSong,
   input  logic [LANES-1:0] noteIn,
   output logic             readyForSong,
   output logic [LANES-1:0] hitRow,
   output logic [7:0]       x,
   output logic [6:0]       y,
   output logic [2:0]       colour,
   output logic             plot,
   output logic             busy
);

   localparam int unsigned PX_W   = cntWidth(CELL_W);
   localparam int unsigned PY_W   = cntWidth(CELL_H);
   localparam int unsigned LANE_W = cntWidth(LANES);
   localparam int unsigned ROW_W  = cntWidth(ROWS);

   drawState_t                  state;
   logic [ROWS-1:0][LANES-1:0]  rows;
   logic [ROWS-1:0][LANES-1:0]  rowsShifted;
   logic [ROWS-1:0][LANES-1:0]  rowView;
   logic                        fieldDone;

   logic [PX_W-1:0]             scanPx;
   logic [PY_W-1:0]             scanPy;
   logic [LANE_W-1:0]           scanLane;
   logic [ROW_W-1:0]            scanRow;
   logic                        scanLast;
   logic                        scanClear;
   logic                        scanStep;

   logic [7:0]                  pixX;
   logic [6:0]                  pixY;
   logic [2:0]                  pixColour;

`ifdef SONG_SCREEN_HIT_LINE_EN
   localparam int unsigned LINE_LEN = LANES * CELL_W;
   localparam int unsigned LINE_W   = cntWidth(LINE_LEN);

   logic [LINE_W-1:0]           lineCnt;
   logic                        lineDone;
   logic [7:0]                  lineX;
   logic [6:0]                  lineY;

   // Hit line sits directly under the bottom row of cells
   always_comb begin
      lineX = 8'(X0 + 32'(lineCnt));
      lineY = 7'(Y0 + ROWS * CELL_H);
   end
`endif

   // Field after a scroll: noteIn enters the top, everything moves down
   always_comb begin
      rowsShifted    = rows;
      rowsShifted[0] = noteIn;
      for (int i = 1; i < int'(ROWS); i++) begin
         rowsShifted[i] = rows[i-1];
      end
   end

   // Pixel 0 is registered in the SHIFT cycle, so it must see the scrolled field
   always_comb begin
      rowView   = (state == ST_SHIFT) ? rowsShifted : rows;
      pixX      = 8'(X0 + 32'(scanLane) * CELL_W + 32'(scanPx));
      pixY      = 7'(Y0 + 32'(scanRow) * CELL_H + 32'(scanPy));
      pixColour = rowView[scanRow][scanLane] ? laneColour(32'(scanLane))
                                             : COLOUR_EMPTY;
   end

   // Counter points at the pixel being registered this cycle
   always_comb begin
      scanClear = !resetn || (state == ST_IDLE);
      scanStep  = (state == ST_CLEAR) || (state == ST_SHIFT) ||
                  ((state == ST_DRAW) && !fieldDone);
   end

   pixel_scan_counter #(
      .ROWS   (ROWS),
      .LANES  (LANES),
      .CELL_W (CELL_W),
      .CELL_H (CELL_H)
   ) u_scan (
      .clock  (clock),
      .clear  (scanClear),
      .enable (scanStep),
      .px     (scanPx),
      .py     (scanPy),
      .lane   (scanLane),
      .row    (scanRow),
      .last   (scanLast)
   );

   // Drawer FSM with registered VGA/handshake outputs
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= ST_CLEAR;
         rows         <= '0;
         hitRow       <= '0;
         fieldDone    <= 1'b0;
         readyForSong <= 1'b0;
         plot         <= 1'b0;
         busy         <= 1'b1;
         x            <= '0;
         y            <= '0;
         colour       <= '0;
`ifdef SONG_SCREEN_HIT_LINE_EN
         lineCnt      <= '0;
         lineDone     <= 1'b0;
`endif
      end else begin
         readyForSong <= 1'b0;
         plot         <= 1'b0;
         x            <= '0;
         y            <= '0;
         colour       <= '0;

         case (state)
            ST_CLEAR: begin
               plot      <= 1'b1;
               x         <= pixX;
               y         <= pixY;
               colour    <= pixColour;
               fieldDone <= scanLast;
               state     <= ST_DRAW;
            end

            ST_IDLE: begin
               if (shiftSong) begin
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               rows      <= rowsShifted;
               hitRow    <= rows[ROWS-1];
               plot      <= 1'b1;
               x         <= pixX;
               y         <= pixY;
               colour    <= pixColour;
               fieldDone <= scanLast;
               state     <= ST_DRAW;
            end

            ST_DRAW: begin
               if (!fieldDone) begin
                  plot      <= 1'b1;
                  x         <= pixX;
                  y         <= pixY;
                  colour    <= pixColour;
                  fieldDone <= scanLast;
               end
`ifdef SONG_SCREEN_HIT_LINE_EN
               else if (!lineDone) begin
                  plot     <= 1'b1;
                  x        <= lineX;
                  y        <= lineY;
                  colour   <= COLOUR_LINE;
                  lineCnt  <= lineCnt + LINE_W'(1);
                  lineDone <= (lineCnt == LINE_W'(LINE_LEN - 1));
               end
`endif
               else begin
                  // Last pixel is on the bus this cycle; handshake next
                  readyForSong <= 1'b1;
                  fieldDone    <= 1'b0;
                  state        <= ST_DONE;
               end
            end

            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
`ifdef SONG_SCREEN_HIT_LINE_EN
               lineCnt  <= '0;
               lineDone <= 1'b0;
`endif
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_screen_drawer.sv
// ---------------------------------------------------------------------------
// tb_song_screen_drawer
// Self-checking bench: a queue-based model of the note field predicts every
// cycle of each redraw (VGA bus, busy, readyForSong) and hitRow.
// ---------------------------------------------------------------------------
module tb_song_screen_drawer;

   localparam int ROWS  = 8;
   localparam int LANES = 4;
   localparam int CW    = 4;
   localparam int CH    = 4;
   localparam int X0    = 48;
   localparam int Y0    = 8;
   localparam int NPIX  = ROWS * LANES * CW * CH;
`ifdef SONG_SCREEN_HIT_LINE_EN
   localparam int NLINE = LANES * CW;
`else
   localparam int NLINE = 0;
`endif
   localparam int NPLOT = NPIX + NLINE;

   logic             clock;
   logic             resetn;
   logic             shiftSong;
   logic [LANES-1:0] noteIn;
   logic             readyForSong;
   logic [LANES-1:0] hitRow;
   logic [7:0]       x;
   logic [6:0]       y;
   logic [2:0]       colour;
   logic             plot;
   logic             busy;

   int compared   = 0;
   int mismatched = 0;

   logic [LANES-1:0] fieldQ[$];   // front = top row
   logic [LANES-1:0] expHit;

   song_screen_drawer #(
      .ROWS   (ROWS),
      .LANES  (LANES),
      .CELL_W (CW),
      .CELL_H (CH),
      .X0     (X0),
      .Y0     (Y0)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .shiftSong    (shiftSong),
      .noteIn       (noteIn),
      .readyForSong (readyForSong),
      .hitRow       (hitRow),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .plot         (plot),
      .busy         (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] laneCol(input int lane);
      case (lane % 4)
         0:       return 3'b100;
         1:       return 3'b010;
         2:       return 3'b001;
         default: return 3'b110;
      endcase
   endfunction

   function automatic logic [31:0] pack(input logic b, input logic r, input logic p,
                                        input logic [7:0] xx, input logic [6:0] yy,
                                        input logic [2:0] cc);
      return {11'b0, b, r, p, xx, yy, cc};
   endfunction

   function automatic logic [31:0] obsVec();
      return pack(busy, readyForSong, plot, x, y, colour);
   endfunction

   // Expected bus for the k-th plotted pixel of a redraw
   function automatic logic [31:0] expPlot(input int k);
      int px, py, lane, row;
      logic [LANES-1:0] note;
      logic [2:0] col;
      if (k < NPIX) begin
         px   = k % CW;
         py   = (k / CW) % CH;
         lane = (k / (CW * CH)) % LANES;
         row  = k / (CW * CH * LANES);
         note = fieldQ[row];
         col  = note[lane] ? laneCol(lane) : 3'b000;
         return pack(1'b1, 1'b0, 1'b1, 8'(X0 + lane * CW + px),
                     7'(Y0 + row * CH + py), col);
      end
      return pack(1'b1, 1'b0, 1'b1, 8'(X0 + k - NPIX), 7'(Y0 + ROWS * CH), 3'b111);
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
      end
   endtask

   task automatic clearModel();
      fieldQ.delete();
      for (int i = 0; i < ROWS; i++) fieldQ.push_back('0);
      expHit = '0;
   endtask

   // Called at the falling edge of the SHIFT/CLEAR cycle; checks the whole redraw.
   // injectAt: plot index at which shiftSong is raised (should be ignored).
   // abortAt: plot index after which resetn is dropped and the pass abandoned.
   task automatic runPass(input int injectAt, input int abortAt);
      chk("pre_plot", 0, obsVec(), pack(1'b1, 1'b0, 1'b0, '0, '0, '0));
      resetn    = 1'b1;
      shiftSong = 1'b0;
      for (int k = 0; k < NPLOT; k++) begin
         @(negedge clock);
         if (k == 0) noteIn = 4'($urandom);
         chk("pixel", k, obsVec(), expPlot(k));
         shiftSong = (k == injectAt);
         if (k == abortAt) begin
            resetn = 1'b0;
            return;
         end
      end
      @(negedge clock);
      shiftSong = 1'b0;
      chk("ready", NPLOT, obsVec(), pack(1'b1, 1'b1, 1'b0, '0, '0, '0));
      @(negedge clock);
      chk("idle", NPLOT + 1, obsVec(), pack(1'b0, 1'b0, 1'b0, '0, '0, '0));
      chk("hitRow", 0, 32'(hitRow), 32'(expHit));
   endtask

   // Called at the falling edge of an IDLE cycle
   task automatic shiftPass(input logic [LANES-1:0] note, input int injectAt,
                            input int abortAt);
      shiftSong = 1'b1;
      noteIn    = note;
      expHit    = fieldQ.pop_back();
      fieldQ.push_front(note);
      @(negedge clock);
      runPass(injectAt, abortAt);
   endtask

   initial begin
      resetn    = 1'b0;
      shiftSong = 1'b0;
      noteIn    = '0;
      clearModel();

      // Reset and blank clear pass
      @(negedge clock);
      @(negedge clock);
      chk("reset_hitRow", 0, 32'(hitRow), 32'(0));
      runPass(-1, -1);

      // Single note in lane 0
      shiftPass(4'b0001, -1, -1);

      // shiftSong during DRAW must be ignored
      shiftPass(4'($urandom), 37, -1);

      // Reset mid-draw, then restarted clear pass
      shiftPass(4'($urandom), -1, 100);
      @(negedge clock);
      clearModel();
      chk("abort_hitRow", 0, 32'(hitRow), 32'(0));
      runPass(-1, -1);

      // Eight lane-3 notes then an empty one
      for (int i = 0; i < 8; i++) shiftPass(4'b1000, -1, -1);
      chk("hit_after_8", 0, 32'(hitRow), 32'(4'b0000));
      shiftPass(4'b0000, -1, -1);
      chk("hit_after_9", 0, 32'(hitRow), 32'(4'b1000));

      // Random notes, some with stray shiftSong during the draw
      for (int i = 0; i < 6; i++) begin
         shiftPass(4'($urandom),
                   (($urandom % 2) == 0) ? -1 : int'($urandom_range(0, NPLOT - 2)),
                   -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
